// File: rtl/table_writer.sv
// Lookup table with an init/clear sweep, a single write port
// and a registered, write-first read port.
module table_writer #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 8,
  parameter logic [DWIDTH-1:0] INIT_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [AWIDTH-1:0] wr_addr,
  input  logic [DWIDTH-1:0] wr_data,
  input  logic              clear_req,
  output logic              busy,
  input  logic [AWIDTH-1:0] rd_addr,
  output logic [DWIDTH-1:0] rd_q,
  output logic [15:0]       wr_count
);

  localparam int DEPTH = 2**AWIDTH;

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_CLEAR
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [AWIDTH-1:0] r_cnt;
  logic [AWIDTH-1:0] w_cnt_nxt;
  logic [DWIDTH-1:0] r_mem [DEPTH];
  logic [DWIDTH-1:0] r_q;
  logic [15:0]       r_wcnt;
  logic              w_last;
  logic              w_busy;
  logic              w_acc;

  assign w_last   = (r_cnt == {AWIDTH{1'b1}});
  assign w_busy   = (r_state != S_IDLE);
  assign wr_ready = (r_state == S_IDLE) && !clear_req;
  assign w_acc    = wr_valid && wr_ready;
  assign busy     = w_busy;
  assign rd_q     = r_q;
  assign wr_count = r_wcnt;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      S_INIT, S_CLEAR: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (w_last) w_state_nxt = S_IDLE;
      end
      S_IDLE: begin
        if (clear_req) begin
          w_state_nxt = S_CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = S_INIT;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Storage has no reset; contents are defined by the sweep.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (w_busy) r_mem[r_cnt] <= INIT_VALUE;
      else if (w_acc) r_mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q <= INIT_VALUE;
    end else if (w_busy) begin
      r_q <= INIT_VALUE;
    end else if (w_acc && (rd_addr == wr_addr)) begin
      r_q <= wr_data;
    end else begin
      r_q <= r_mem[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wcnt <= '0;
    end else if (w_acc && (r_wcnt != 16'hFFFF)) begin
      r_wcnt <= r_wcnt + 16'd1;
    end
  end

endmodule

// File: doc/table_writer.md
TABLE_WRITER -- requirements
Module: table_writer

Interface
REQ-001 SHALL have parameter DWIDTH, default 8, table word width in bits.
REQ-002 SHALL have parameter AWIDTH, default 8, table address width; depth = 2**AWIDTH entries.
REQ-003 SHALL have parameter INIT_VALUE, default 0, word written to every entry by sweeps.
REQ-004 SHALL use one clock; reset is synchronous and active-low.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst_n  input  1  synchronous active-low reset.
REQ-007 wr_valid  input  1  write command valid.
REQ-008 wr_ready  output  1  write command accepted when wr_valid and wr_ready are both high at a clk edge.
REQ-009 wr_addr  input  AWIDTH  write address.
REQ-010 wr_data  input  DWIDTH  write data.
REQ-011 clear_req  input  1  single-cycle request to sweep the whole table to INIT_VALUE.
REQ-012 busy  output  1  high while in INIT or CLEAR.
REQ-013 rd_addr  input  AWIDTH  lookup address.
REQ-014 rd_q  output  DWIDTH  registered lookup data.
REQ-015 wr_count  output  16  number of accepted writes, saturating.

Function
REQ-016 SHALL contain internal storage of 2**AWIDTH words, one write path and one independent read path.
REQ-017 SHALL implement FSM states INIT, IDLE, CLEAR; INIT is entered on reset.
REQ-018 INIT/CLEAR: address counter starts at 0, writes INIT_VALUE to one entry per cycle, increments by 1; after writing entry 2**AWIDTH-1 the FSM moves to IDLE on the next edge; sweep lasts exactly 2**AWIDTH cycles.
REQ-019 IDLE -> CLEAR on any edge where clear_req=1; clear_req in INIT or CLEAR SHALL be ignored, with no restart and no queuing.
REQ-020 wr_ready SHALL equal (state==IDLE) and not clear_req, combinationally; clear_req wins over a simultaneous write.
REQ-021 An accepted write SHALL update mem[wr_addr] to wr_data at that edge.
REQ-022 busy SHALL equal (state!=IDLE).
REQ-023 rd_q SHALL have 1-cycle latency: the value at edge t+1 reflects rd_addr sampled at edge t.
REQ-024 While busy at edge t, rd_q at t+1 SHALL be INIT_VALUE regardless of rd_addr.
REQ-025 Collision: if a write is accepted at edge t and rd_addr==wr_addr at t, rd_q at t+1 SHALL be the new wr_data (write-first forwarding).
REQ-026 wr_count SHALL increment by 1 per accepted write, saturate at 0xFFFF, and not be cleared by clear_req.
REQ-027 Writes to any address, including wrap-around values 0 and 2**AWIDTH-1, SHALL behave identically.

Reset
REQ-028 rst_n=0 at an edge SHALL set state=INIT, the sweep counter to 0, wr_count=0 and rd_q=INIT_VALUE; busy=1 and wr_ready=0 from that edge.
REQ-029 Reset asserted mid-sweep or mid-write SHALL abandon the operation and restart the INIT sweep from address 0.
REQ-030 Table contents are undefined until the first INIT sweep completes.

Verification (AWIDTH=4, DWIDTH=8, INIT_VALUE=0)
REQ-031 Reset, then idle -> busy=1 for exactly 16 cycles after rst_n rises, then busy=0 and wr_ready=1; reading all 16 addresses returns 0x00.
REQ-032 Write addr 3 = 0xA5, then read addr 3 -> rd_q=0xA5 one cycle after rd_addr presented; wr_count=1.
REQ-033 Same-cycle write addr 7 = 0x3C with rd_addr=7 -> rd_q=0x3C on the next cycle.
REQ-034 Assert wr_valid and clear_req together in IDLE -> write not accepted, wr_count unchanged, busy for 16 cycles, then all entries read 0x00.
REQ-035 Pulse clear_req again 5 cycles into CLEAR -> ignored; busy still drops exactly 16 cycles after the original clear.
REQ-036 Assert rst_n=0 for one cycle at sweep address 9 -> sweep restarts at 0; busy lasts 16 more cycles; wr_count=0.
